// File: rtl/ft_bus_pkg.sv
// rtl/ft_bus_pkg.sv - shared state encoding and default timing for the FT245 bus arbiter
package ft_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RD_STROBE = 2'd1,
        ST_WR_STROBE = 2'd2,
        ST_RECOVER   = 2'd3
    } ft_state_t;

    localparam int DEF_STROBE_CYC = 4;
    localparam int DEF_TURN_CYC   = 3;

endpackage

// File: rtl/ft_flag_sync.sv
// rtl/ft_flag_sync.sv - two-flop synchronizer for an active-low FT245 status flag
module ft_flag_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic flag,
    output logic flag_s
);

    logic meta;

    // Resets to 1 so a flag reads as "not asserted" until really sampled low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta   <= 1'b1;
            flag_s <= 1'b1;
        end else begin
            meta   <= flag;
            flag_s <= meta;
        end
    end

endmodule

// File: rtl/ft245_bus_arbiter.sv
// rtl/ft245_bus_arbiter.sv - arbitrates one RX consumer and two TX producers onto an FT245 FIFO bus
module ft245_bus_arbiter
    import ft_bus_pkg::*;
#(
    parameter int STROBE_CYC = DEF_STROBE_CYC,
    parameter int TURN_CYC   = DEF_TURN_CYC
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxf,
    input  logic       txe,
    output logic       rd,
    output logic       wr,
    inout  wire  [7:0] data,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       tx0_req,
    input  logic [7:0] tx0_data,
    output logic       tx0_ack,
    input  logic       tx1_req,
    input  logic [7:0] tx1_data,
    output logic       tx1_ack
);

    localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYC - 1);
    localparam logic [3:0] TURN_LOAD   = 4'(TURN_CYC - 1);

    logic       rxf_s;
    logic       txe_s;
    ft_state_t  state;
    ft_state_t  next_state;
    logic [3:0] cnt;
    logic       cnt_load;
    logic [3:0] cnt_val;
    logic       last_rx;
    logic       rr_tx1;
    logic       ack_tx1;
    logic [7:0] tx_byte;
    logic       data_oe;

    logic       rd_elig;
    logic       wr_elig;
    logic       sel_tx1;
    logic       grant_rd;
    logic       grant_wr;
    logic       end_rd;
    logic       end_wr;

    ft_flag_sync u_rxf_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .flag   (rxf),
        .flag_s (rxf_s)
    );

    ft_flag_sync u_txe_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .flag   (txe),
        .flag_s (txe_s)
    );

    assign data = data_oe ? tx_byte : 8'bz;

    assign rd_elig = !rxf_s && rx_ready;
    assign wr_elig = !txe_s && (tx0_req || tx1_req);
    assign sel_tx1 = tx1_req && (!tx0_req || rr_tx1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        cnt_load   = 1'b0;
        cnt_val    = 4'd0;
        grant_rd   = 1'b0;
        grant_wr   = 1'b0;
        end_rd     = 1'b0;
        end_wr     = 1'b0;
        case (state)
            ST_IDLE: begin
                // When both sides are eligible, serve the type not served last time
                if (rd_elig && (!wr_elig || !last_rx)) begin
                    grant_rd   = 1'b1;
                    next_state = ST_RD_STROBE;
                    cnt_load   = 1'b1;
                    cnt_val    = STROBE_LOAD;
                end else if (wr_elig) begin
                    grant_wr   = 1'b1;
                    next_state = ST_WR_STROBE;
                    cnt_load   = 1'b1;
                    cnt_val    = STROBE_LOAD;
                end
            end
            ST_RD_STROBE: begin
                if (cnt == 4'd0) begin
                    end_rd     = 1'b1;
                    next_state = ST_RECOVER;
                    cnt_load   = 1'b1;
                    cnt_val    = TURN_LOAD;
                end
            end
            ST_WR_STROBE: begin
                if (cnt == 4'd0) begin
                    end_wr     = 1'b1;
                    next_state = ST_RECOVER;
                    cnt_load   = 1'b1;
                    cnt_val    = TURN_LOAD;
                end
            end
            ST_RECOVER: begin
                if (cnt == 4'd0) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 4'd0;
        end else if (cnt_load) begin
            cnt <= cnt_val;
        end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Strobes and bus enable are flops so reset clears them without waiting for a clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd       <= 1'b1;
            wr       <= 1'b1;
            data_oe  <= 1'b0;
            tx_byte  <= 8'd0;
            last_rx  <= 1'b0;
            rr_tx1   <= 1'b0;
            ack_tx1  <= 1'b0;
            rx_data  <= 8'd0;
            rx_valid <= 1'b0;
            tx0_ack  <= 1'b0;
            tx1_ack  <= 1'b0;
        end else begin
            rx_valid <= end_rd;
            tx0_ack  <= end_wr && !ack_tx1;
            tx1_ack  <= end_wr && ack_tx1;
            if (grant_rd) begin
                rd      <= 1'b0;
                last_rx <= 1'b1;
            end
            if (end_rd) begin
                rd      <= 1'b1;
                rx_data <= data;
            end
            if (grant_wr) begin
                wr      <= 1'b0;
                data_oe <= 1'b1;
                tx_byte <= sel_tx1 ? tx1_data : tx0_data;
                ack_tx1 <= sel_tx1;
                last_rx <= 1'b0;
                rr_tx1  <= !rr_tx1;
            end
            if (end_wr) begin
                wr <= 1'b1;
            end
            // Byte stays on the bus through the first recovery cycle for hold time
            if (state == ST_RECOVER) begin
                data_oe <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ft245_bus_arbiter.sv
// tb/tb_ft245_bus_arbiter.sv - directed self-checking bench for ft245_bus_arbiter
module tb_ft245_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxf = 1'b1;
    logic       txe = 1'b1;
    logic       rd;
    logic       wr;
    wire  [7:0] data;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx0_req = 1'b0;
    logic [7:0] tx0_data = 8'd0;
    logic       tx0_ack;
    logic       tx1_req = 1'b0;
    logic [7:0] tx1_data = 8'd0;
    logic       tx1_ack;
    logic [7:0] ft_byte = 8'd0;

    int errors = 0;
    int checks = 0;

    int rd_run = 0, rd_width = 0, rd_low_total = 0;
    int wr_run = 0, wr_width = 0, wr_low_total = 0;
    int overlap = 0, wr_data_bad = 0;
    int rv_cnt = 0, a0_cnt = 0, a1_cnt = 0;
    int glog [0:63];
    int gcnt = 0;
    logic       chk_wr = 1'b0;
    logic [7:0] exp_wr = 8'd0;

    always #5 clk = ~clk;

    for (genvar i = 0; i < 8; i++) begin : g_pu
        pullup (data[i]);
    end

    assign data = (rd == 1'b0) ? ft_byte : 8'bz;

    ft245_bus_arbiter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rxf      (rxf),
        .txe      (txe),
        .rd       (rd),
        .wr       (wr),
        .data     (data),
        .rx_ready (rx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx0_req  (tx0_req),
        .tx0_data (tx0_data),
        .tx0_ack  (tx0_ack),
        .tx1_req  (tx1_req),
        .tx1_data (tx1_data),
        .tx1_ack  (tx1_ack)
    );

    always @(negedge clk) begin
        if (!rd) begin
            rd_run++;
            rd_low_total++;
        end else if (rd_run != 0) begin
            rd_width = rd_run;
            rd_run = 0;
        end
        if (!wr) begin
            wr_run++;
            wr_low_total++;
        end else if (wr_run != 0) begin
            wr_width = wr_run;
            wr_run = 0;
        end
        if (!rd && !wr) overlap++;
        if (!wr && chk_wr && data !== exp_wr) wr_data_bad++;
        if (rx_valid) begin
            rv_cnt++;
            if (gcnt < 64) glog[gcnt] = 0;
            gcnt++;
        end
        if (tx0_ack) begin
            a0_cnt++;
            if (gcnt < 64) glog[gcnt] = 1;
            gcnt++;
        end
        if (tx1_ack) begin
            a1_cnt++;
            if (gcnt < 64) glog[gcnt] = 2;
            gcnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic hit(input int which);
        case (which)
            0:       return rd == 1'b0;
            1:       return wr == 1'b0;
            2:       return tx0_ack == 1'b1;
            3:       return tx1_ack == 1'b1;
            default: return rx_valid == 1'b1;
        endcase
    endfunction

    task automatic wait_for(input string tag, input int which, input int budget, output int n);
        n = 0;
        @(negedge clk);
        n = 1;
        while (!hit(which) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(hit(which)), 32'd1);
    endtask

    initial begin
        int n;
        int s0, s1, s2;

        cyc(3);
        check("reset_rd", 32'(rd), 32'd1);
        check("reset_wr", 32'(wr), 32'd1);
        check("reset_data_z", 32'(data), 32'hFF);
        check("reset_rx_data", 32'(rx_data), 32'd0);
        check("reset_rx_valid", 32'(rx_valid), 32'd0);
        check("reset_acks", 32'({tx0_ack, tx1_ack}), 32'd0);
        rst_n = 1'b1;
        cyc(2);

        // single read of 0xA5
        s0 = rv_cnt;
        ft_byte = 8'hA5;
        rx_ready = 1'b1;
        rxf = 1'b0;
        wait_for("rd1_start", 0, 10, n);
        rxf = 1'b1;
        wait_for("rd1_valid", 4, 20, n);
        check("rd1_rx_data", 32'(rx_data), 32'hA5);
        check("rd1_rd_high", 32'(rd), 32'd1);
        cyc(3);
        check("rd1_width", 32'(rd_width), 32'd4);
        check("rd1_valid_pulses", 32'(rv_cnt - s0), 32'd1);

        // single write of 0x3C on tx0
        s0 = a0_cnt;
        exp_wr = 8'h3C;
        chk_wr = 1'b1;
        tx0_data = 8'h3C;
        tx0_req = 1'b1;
        txe = 1'b0;
        wait_for("wr1_start", 1, 10, n);
        check("wr1_data_entry", 32'(data), 32'h3C);
        wait_for("wr1_ack", 2, 20, n);
        tx0_req = 1'b0;
        txe = 1'b1;
        check("wr1_hold_data", 32'(data), 32'h3C);
        check("wr1_wr_high", 32'(wr), 32'd1);
        cyc(1);
        check("wr1_data_released", 32'(data), 32'hFF);
        cyc(3);
        check("wr1_width", 32'(wr_width), 32'd4);
        check("wr1_ack_pulses", 32'(a0_cnt - s0), 32'd1);
        check("wr1_data_bad", 32'(wr_data_bad), 32'd0);
        chk_wr = 1'b0;

        // continuous contention from a fresh reset
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        s0 = gcnt;
        ft_byte = 8'h77;
        tx0_data = 8'h11;
        tx1_data = 8'h22;
        tx0_req = 1'b1;
        tx1_req = 1'b1;
        rxf = 1'b0;
        txe = 1'b0;
        n = 0;
        while (gcnt - s0 < 6 && n < 150) begin
            @(negedge clk);
            n++;
        end
        rxf = 1'b1;
        txe = 1'b1;
        tx0_req = 1'b0;
        tx1_req = 1'b0;
        check("arb_six_grants", 32'(gcnt - s0 >= 6), 32'd1);
        cyc(12);
        check("arb_g0_rx", 32'(glog[s0]), 32'd0);
        check("arb_g1_tx0", 32'(glog[s0 + 1]), 32'd1);
        check("arb_g2_rx", 32'(glog[s0 + 2]), 32'd0);
        check("arb_g3_tx1", 32'(glog[s0 + 3]), 32'd2);
        check("arb_g4_rx", 32'(glog[s0 + 4]), 32'd0);
        check("arb_g5_tx0", 32'(glog[s0 + 5]), 32'd1);

        // consumer back-pressure
        rx_ready = 1'b0;
        rxf = 1'b0;
        s0 = rd_low_total;
        cyc(10);
        check("bp_no_rd", 32'(rd_low_total - s0), 32'd0);
        rx_ready = 1'b1;
        wait_for("bp_rd_start", 0, 10, n);
        check("bp_latency_le3", 32'(n <= 3), 32'd1);
        rxf = 1'b1;
        wait_for("bp_valid", 4, 20, n);
        cyc(4);

        // tx1 gated by txe, txe withdrawn mid-strobe
        s0 = wr_low_total;
        s1 = a1_cnt;
        s2 = a0_cnt;
        exp_wr = 8'h5A;
        chk_wr = 1'b1;
        tx1_data = 8'h5A;
        tx1_req = 1'b1;
        cyc(10);
        check("txe_gate_no_wr", 32'(wr_low_total - s0), 32'd0);
        txe = 1'b0;
        wait_for("txe_wr_start", 1, 10, n);
        txe = 1'b1;
        wait_for("txe_ack1", 3, 20, n);
        tx1_req = 1'b0;
        cyc(3);
        check("txe_wr_width", 32'(wr_width), 32'd4);
        check("txe_ack1_pulses", 32'(a1_cnt - s1), 32'd1);
        check("txe_no_ack0", 32'(a0_cnt - s2), 32'd0);
        check("txe_data_bad", 32'(wr_data_bad), 32'd0);
        chk_wr = 1'b0;

        // reset in second cycle of a write strobe
        s0 = a0_cnt;
        tx0_data = 8'hC3;
        tx0_req = 1'b1;
        txe = 1'b0;
        wait_for("rst_wr_start", 1, 10, n);
        cyc(1);
        check("rst_wr_still_low", 32'(wr), 32'd0);
        rst_n = 1'b0;
        #1;
        check("rst_wr_high", 32'(wr), 32'd1);
        check("rst_data_z", 32'(data), 32'hFF);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        tx0_req = 1'b0;
        txe = 1'b1;
        cyc(2);
        rst_n = 1'b1;
        cyc(10);
        check("rst_no_ack0", 32'(a0_cnt - s0), 32'd0);
        check("rst_wr_idle", 32'(wr), 32'd1);
        check("never_rd_wr_overlap", 32'(overlap), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ft245_bus_arbiter.md
FT245_BUS_ARBITER -- requirements
Module: ft245_bus_arbiter

Interface
REQ-001 Parameter STROBE_CYC, default 4: rd/wr low-pulse width in clk cycles; legal range 2..15.
REQ-002 Parameter TURN_CYC, default 3: recovery cycles with rd=wr=1 and data released between accesses; legal range 3..15.
REQ-003 clk  input  1  single clock; all state on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 rxf  input  1  FT245 RX-data-available, active-low, asynchronous to clk.
REQ-006 txe  input  1  FT245 TX-space-available, active-low, asynchronous to clk.
REQ-007 rd  output  1  FT245 read strobe, active-low.
REQ-008 wr  output  1  FT245 write strobe, active-low.
REQ-009 data  inout  8  FT245 data bus; driven only while writing, else high-Z.
REQ-010 rx_ready  input  1  consumer can accept a byte.
REQ-011 rx_data  output  8  last byte read; stable until next rx_valid.
REQ-012 rx_valid  output  1  one-cycle pulse, rx_data new.
REQ-013 tx0_req, tx1_req  input  1 each  producer has a byte; held until its ack.
REQ-014 tx0_data, tx1_data  input  8 each  byte to send; held stable while req high.
REQ-015 tx0_ack, tx1_ack  output  1 each  one-cycle pulse, byte written.

Function
REQ-016 rxf and txe SHALL each pass a 2-FF synchronizer; all decisions use synchronized values only.
REQ-017 FSM states SHALL be IDLE, RD_STROBE, WR_STROBE, RECOVER.
REQ-018 IDLE: read eligible = rxf_s==0 and rx_ready==1; write eligible = txe_s==0 and (tx0_req or tx1_req).
REQ-019 Both eligible: grant SHALL alternate with the previous grant type (last_rx flag); only one eligible: grant it; none: stay IDLE.
REQ-020 Between tx0 and tx1 SHALL be round-robin; pointer toggles only on a TX grant.
REQ-021 RD_STROBE: rd=0 for exactly STROBE_CYC cycles; data sampled into rx_data on the last of them.
REQ-022 rx_valid SHALL pulse in the first RECOVER cycle after a read.
REQ-023 WR_STROBE: data driven with the granted byte from the entry cycle; wr=0 for STROBE_CYC cycles; data held through the cycle wr returns high.
REQ-024 Granted txN_ack SHALL pulse in the first RECOVER cycle; data released (Z) from the second RECOVER cycle.
REQ-025 RECOVER SHALL last TURN_CYC cycles, then IDLE; minimum access period = STROBE_CYC + TURN_CYC + 1.
REQ-026 rxf/txe deasserting mid-strobe SHALL NOT abort the access; the strobe completes at full width.
REQ-027 A txN_req dropped before grant SHALL produce no ack; rd and wr SHALL never be low simultaneously.

Reset
REQ-028 While rst_n=0: rd=1, wr=1, data=Z, rx_data=0, rx_valid=0, tx0_ack=tx1_ack=0, FSM=IDLE, last_rx=0, rr pointer=tx0, synchronizers=1.
REQ-029 Reset asserted mid-strobe SHALL raise rd/wr and release data immediately, with no ack or rx_valid issued.

Structure
REQ-030 Package ft_bus_pkg SHALL hold the FSM state enum and default STROBE_CYC/TURN_CYC constants.
REQ-031 One sub-module, ft_flag_sync (2-FF synchronizer with reset value 1), instantiated for rxf and txe.
REQ-032 A single 4-bit down-counter shared by STROBE and RECOVER phases.

Verification
REQ-033 rxf low, rx_ready=1, FT model drives 0xA5 -> rd low 4 cycles, rx_data=0xA5, one rx_valid pulse.
REQ-034 tx0_req with 0x3C, txe low -> wr low 4 cycles, data=0x3C throughout, one tx0_ack, data Z afterwards.
REQ-035 rxf low and tx0_req/tx1_req held continuously -> grant sequence RX, TX0, RX, TX1, RX, TX0.
REQ-036 rxf low with rx_ready=0 -> no rd strobe; raise rx_ready -> read starts within 3 cycles (sync + IDLE).
REQ-037 txe high with tx1_req held -> no wr; txe falls -> write completes; txe rises mid-strobe -> wr still 4 cycles low.
REQ-038 rst_n pulsed low in 2nd cycle of WR_STROBE -> wr=1 and data=Z same cycle, no tx ack.
